sumsq_radicand_feeder: RTL and testbench
========================================

// Module: sumsq_radicand_feeder
// PURPOSE
//  Upstream stage of the integer square-root unit. Accepts an operand pair (x, y), computes
//  x*x + y*y with a sequential shift-add multiplier (one partial product per cycle), and
//  presents the result as the radicand for the sqrt stage. Together the two stages give a
//  vector-magnitude path. Valid/ready handshake on both sides; holds one transaction at a time.
// PARAMETERS
//  IN_W   default 4  width of each unsigned operand x, y
//  OUT_W  default 8  width of radicand output (matches sqrt input width)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      feeder can accept a pair (high only in IDLE)
//  x          in   IN_W   operand x, unsigned
//  y          in   IN_W   operand y, unsigned
//  out_valid  out  1      radicand valid
//  out_ready  in   1      sqrt stage accepts radicand
//  radicand   out  OUT_W  x*x + y*y, clamped or truncated to OUT_W (see CONFIGURATION)
//  ovf        out  1      true sum exceeded 2**OUT_W-1; qualified by out_valid
//  busy       out  1      high in SQ_X, SQ_Y or HOLD
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1, out_valid=0, radicand=0, ovf=0, busy=0;
//    internal accumulator, operand latches and bit counter cleared. Reset mid-operation drops
//    the transaction; no partial result is ever presented.
//  - Accumulator width 2*IN_W+1 bits, unsigned; no loss before the output stage.
//  - FSM states:
//    IDLE : in_ready=1. On in_valid&&in_ready latch x,y; clear acc; cnt=0 -> SQ_X.
//    SQ_X : each cycle, if x[cnt] then acc += x<<cnt; cnt++. After IN_W cycles cnt=0 -> SQ_Y.
//    SQ_Y : same with y. After IN_W cycles, load radicand/ovf from acc -> HOLD.
//    HOLD : out_valid=1; radicand, ovf stable. On out_ready -> IDLE (out_valid=0 next cycle).
//  - Latency: handshake at edge T0 -> out_valid high after edge T0+2*IN_W (8 cycles default).
//  - Throughput: at most one pair per 2*IN_W+2 cycles with out_ready tied high.
//  - in_valid while busy is ignored (in_ready=0); x,y only sampled at the accept edge, so
//    changing x,y after acceptance has no effect.
//  - out_ready while out_valid=0 is ignored. out_ready held low keeps HOLD indefinitely with
//    outputs frozen.
//  - Back-to-back: the in_valid handshake is only taken in IDLE; the earliest accept after a
//    completed HOLD is the cycle after the out handshake.
//  - ovf = (acc > 2**OUT_W-1), computed once on entry to HOLD.
// CONFIGURATION
//  - SUMSQ_SAT_EN defined: radicand = ovf ? {OUT_W{1'b1}} : acc[OUT_W-1:0] (saturating).
//  - SUMSQ_SAT_EN undefined: radicand = acc[OUT_W-1:0] (modulo 2**OUT_W); ovf still reported.
//  - Nothing else changes: FSM, latency and handshake are identical in both builds.
// TESTING
//  1. Reset: rst_n low mid-cycle -> immediately in_ready=1, out_valid=0, radicand=0, ovf=0.
//  2. x=3,y=4, out_ready=1 -> out_valid 8 cycles after accept, radicand=25, ovf=0.
//  3. x=15,y=15 -> sum 450, ovf=1; radicand=255 with SUMSQ_SAT_EN, 194 without.
//  4. x=0,y=0 -> radicand=0, ovf=0, same 8-cycle latency; x=11,y=0 -> 121.
//  5. Backpressure: x=5,y=12 with out_ready=0 for 10 cycles -> radicand=169 held stable,
//     in_ready=0 throughout; out_ready=1 -> IDLE next cycle; new pair accepted the cycle after.
//  6. Reset asserted in SQ_Y for x=7,y=7 -> no out_valid; after release, x=1,y=2 -> radicand=5.

Source files
------------

// File: rtl/sumsq_radicand_feeder.sv
// Feeds x*x + y*y to the sqrt stage via a one-partial-product-per-cycle shift-add multiplier.
// Latency 2*IN_W cycles accept-to-out_valid; single transaction in flight, in_ready only in IDLE; SUMSQ_SAT_EN selects saturating radicand.
module sumsq_radicand_feeder #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] radicand,
  output logic             ovf,
  output logic             busy
);

  localparam int ACC_W = 2 * IN_W + 1;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [EXT_W-1:0] LIMIT    = EXT_W'({OUT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, SQ_X, SQ_Y, HOLD} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   x_q, y_q, opnd;
  logic [ACC_W-1:0]  acc, acc_sum, pp;
  logic [CNT_W-1:0]  cnt;
  logic [EXT_W-1:0]  sum_ext;
  logic [OUT_W-1:0]  rad_nxt;
  logic              ovf_nxt, accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);

  // Sum including the current partial product, so the final SQ_Y cycle can load the output directly.
  always_comb begin
    opnd    = (state == SQ_Y) ? y_q : x_q;
    pp      = opnd[cnt] ? (ACC_W'(opnd) << cnt) : '0;
    acc_sum = acc + pp;
    sum_ext = EXT_W'(acc_sum);
    ovf_nxt = (sum_ext > LIMIT);
`ifdef SUMSQ_SAT_EN
    rad_nxt = ovf_nxt ? {OUT_W{1'b1}} : sum_ext[OUT_W-1:0];
`else
    rad_nxt = sum_ext[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SQ_X;
      SQ_X:    if (last)      state_nxt = SQ_Y;
      SQ_Y:    if (last)      state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      radicand <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q <= x;
            y_q <= y;
            acc <= '0;
            cnt <= '0;
          end
        end
        SQ_X, SQ_Y: begin
          acc <= acc_sum;
          cnt <= last ? '0 : cnt + CNT_W'(1);
          if (state == SQ_Y && last) begin
            radicand <= rad_nxt;
            ovf      <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumsq_radicand_feeder.sv
// Scoreboard bench for sumsq_radicand_feeder: directed operand pairs, monitor checks radicand/ovf/latency.
module tb_sumsq_radicand_feeder;

  localparam int LAT = 8;
`ifdef SUMSQ_SAT_EN
  localparam logic [7:0] R_15_15 = 8'd255;
  localparam logic [7:0] R_12_12 = 8'd255;
`else
  localparam logic [7:0] R_15_15 = 8'd194;
  localparam logic [7:0] R_12_12 = 8'd32;
`endif

  typedef struct {
    logic [7:0] rad;
    logic       ovf;
    int         acc_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] radicand;
  logic       ovf;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 0;
  exp_t sb[$];

  sumsq_radicand_feeder #(.IN_W(4), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .radicand(radicand), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare on the first cycle of each out_valid pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid && !seen) begin
      exp_t e;
      seen = 1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: radicand %0d with empty scoreboard", radicand);
      end else begin
        e = sb.pop_front();
        chk("radicand", int'(radicand), int'(e.rad));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("latency", cyc - e.acc_cyc, LAT);
      end
    end else if (!out_valid) begin
      seen = 0;
    end
  end

  task automatic send(input logic [3:0] xv, input logic [3:0] yv,
                      input logic [7:0] er, input logic eo, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    x = xv;
    y = yv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 4'($urandom);
    y = 4'($urandom);
    if (push) sb.push_back('{er, eo, cyc});
  endtask

  task automatic wait_out();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("out_timeout", 0, 1);
  endtask

  initial begin
    #3;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_radicand", int'(radicand), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(4'd3, 4'd4, 8'd25, 1'b0, 1);   wait_out();
    send(4'd15, 4'd15, R_15_15, 1'b1, 1); wait_out();
    send(4'd0, 4'd0, 8'd0, 1'b0, 1);    wait_out();
    send(4'd11, 4'd0, 8'd121, 1'b0, 1); wait_out();
    send(4'd12, 4'd12, R_12_12, 1'b1, 1); wait_out();
    send(4'd10, 4'd11, 8'd221, 1'b0, 1); wait_out();

    // Requests while busy must be ignored.
    send(4'd9, 4'd13, 8'd250, 1'b0, 1);
    in_valid = 1'b1;
    x = 4'd15;
    y = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_in_ready", int'(in_ready), 0);
    chk("busy_flag", int'(busy), 1);
    in_valid = 1'b0;
    wait_out();

    // Backpressure: hold result for 10 cycles.
    out_ready = 1'b0;
    send(4'd5, 4'd12, 8'd169, 1'b0, 1);
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_radicand", int'(radicand), 169);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
    send(4'd1, 4'd1, 8'd2, 1'b0, 1);
    wait_out();

    // Reset during SQ_Y drops the transaction.
    send(4'd7, 4'd7, 8'd98, 1'b0, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_radicand", int'(radicand), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("dropped_out_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(4'd1, 4'd2, 8'd5, 1'b0, 1);
    wait_out();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
